// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and state encoding for the memory bus arbiter.
// The arbiter grants the single bus port to either the data path or the fetch path.
package mem_bus_arbiter_pkg;

  localparam logic [31:0] ZeroWord       = 32'h0000_0000;
  localparam logic        Stop           = 1'b1;
  localparam int unsigned TimeoutDefault = 255;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DM_ACC   = 3'd1,
    IF_ACC   = 3'd2,
    IF_DRAIN = 3'd3,
    DM_DONE  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Shared memory bus signals.
// The arbiter is the master; the memory or slave model uses the slave modport.
interface mem_bus_arbiter_if;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport master (
    output cyc, stb, we, sel, addr, wdata, err,
    input  rdata, ack
  );

  modport slave (
    input  cyc, stb, we, sel, addr, wdata, err,
    output rdata, ack
  );

endinterface

// File: rtl/mem_bus_arbiter_bus_watchdog.sv
// Acknowledge watchdog for one bus transaction.
// expire_o fires on the cycle whose edge would bring the unacked count to TIMEOUT.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam int unsigned   CW        = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] LastCount = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic          Enabled   = (TIMEOUT != 0);

  logic [CW-1:0] count_q, count_d;
  logic          running_q, running_d;

  assign expire_o = Enabled & running_q & ~ack_i & (count_q == LastCount);

  always_comb begin
    count_d   = count_q;
    running_d = running_q;
    if (start_i) begin
      count_d   = '0;
      running_d = 1'b1;
    end else if (running_q) begin
      if (ack_i || expire_o) begin
        count_d   = '0;
        running_d = 1'b0;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      running_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      running_q <= running_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus arbiter between instruction fetch and data access.
// Data access has fixed priority; fetched words are buffered while IF/ID is stalled.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall_i,
  input  logic                flush_i,
  input  logic                if_req_i,
  input  logic [31:0]         if_addr_i,
  output logic [31:0]         if_data_o,
  output logic                if_ready_o,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [3:0]          dm_sel_i,
  input  logic [31:0]         dm_addr_i,
  input  logic [31:0]         dm_data_i,
  output logic [31:0]         dm_data_o,
  output logic                dm_ready_o,
  output logic                stallreq_if_o,
  output logic                stallreq_mem_o,
  mem_bus_arbiter_if.master   bus
);

  arb_state_e  state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] dm_data_q, dm_data_d;
  logic        dm_ready_q, dm_ready_d;
  logic [31:0] if_buf_q, if_buf_d;
  logic        if_valid_q, if_valid_d;
  logic        err_q;
  logic        if_set;
  logic        wd_start;
  logic        wd_expire;
  logic        bus_done;
  logic [31:0] rdata_eff;
  logic        fetch_ok;

  wire unused_stall_bits = ^{stall_i[5:2], stall_i[0]};

  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .start_i  (wd_start),
    .ack_i    (bus.ack),
    .expire_o (wd_expire)
  );

  // A watchdog expiry completes the access as if acked with a zero word.
  assign bus_done  = bus.ack | wd_expire;
  assign rdata_eff = wd_expire ? ZeroWord : bus.rdata;
  assign fetch_ok  = if_req_i & ~if_valid_q & ~flush_i;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    dm_data_d  = dm_data_q;
    dm_ready_d = 1'b0;
    if_buf_d   = if_buf_q;
    if_set     = 1'b0;
    wd_start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dm_req_i) begin
          state_d  = DM_ACC;
          cyc_d    = 1'b1;
          we_d     = dm_we_i;
          sel_d    = dm_sel_i;
          addr_d   = dm_addr_i;
          wdata_d  = dm_data_i;
          wd_start = 1'b1;
        end else if (fetch_ok) begin
          state_d  = IF_ACC;
          cyc_d    = 1'b1;
          we_d     = 1'b0;
          sel_d    = 4'hF;
          addr_d   = if_addr_i;
          wdata_d  = ZeroWord;
          wd_start = 1'b1;
        end
      end
      DM_ACC: begin
        if (bus_done) begin
          state_d    = DM_DONE;
          cyc_d      = 1'b0;
          dm_data_d  = rdata_eff;
          dm_ready_d = 1'b1;
        end
      end
      DM_DONE: state_d = IDLE;
      IF_ACC: begin
        if (bus_done) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          if (!flush_i) begin
            if_buf_d = rdata_eff;
            if_set   = 1'b1;
          end
        end else if (flush_i) begin
          state_d  = IF_DRAIN;
          wd_start = 1'b1;
        end
      end
      IF_DRAIN: begin
        if (bus_done) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase

    // A flush or a consumed word always wins over a fresh fill.
    if_valid_d = if_valid_q;
    if (flush_i) begin
      if_valid_d = 1'b0;
    end else if (if_valid_q && !stall_i[1]) begin
      if_valid_d = 1'b0;
    end else if (if_set) begin
      if_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 4'h0;
      addr_q     <= ZeroWord;
      wdata_q    <= ZeroWord;
      dm_data_q  <= ZeroWord;
      dm_ready_q <= 1'b0;
      if_buf_q   <= ZeroWord;
      if_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      dm_data_q  <= dm_data_d;
      dm_ready_q <= dm_ready_d;
      if_buf_q   <= if_buf_d;
      if_valid_q <= if_valid_d;
      err_q      <= wd_expire;
    end
  end

  assign bus.cyc        = cyc_q;
  assign bus.stb        = cyc_q;
  assign bus.we         = we_q;
  assign bus.sel        = sel_q;
  assign bus.addr       = addr_q;
  assign bus.wdata      = wdata_q;
  assign bus.err        = err_q;
  assign dm_data_o      = dm_data_q;
  assign dm_ready_o     = dm_ready_q;
  assign if_data_o      = if_buf_q;
  assign if_ready_o     = if_valid_q;
  assign stallreq_mem_o = dm_req_i & (state_q != DM_DONE);
  assign stallreq_if_o  = fetch_ok;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter with a hand-driven bus slave.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stallVec;
  logic        flush;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic [31:0] ifData;
  logic        ifReady;
  logic        dmReq;
  logic        dmWe;
  logic [3:0]  dmSel;
  logic [31:0] dmAddr;
  logic [31:0] dmWdata;
  logic [31:0] dmRdata;
  logic        dmReady;
  logic        stallReqIf;
  logic        stallReqMem;

  int passCount  = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stallVec),
    .flush_i        (flush),
    .if_req_i       (ifReq),
    .if_addr_i      (ifAddr),
    .if_data_o      (ifData),
    .if_ready_o     (ifReady),
    .dm_req_i       (dmReq),
    .dm_we_i        (dmWe),
    .dm_sel_i       (dmSel),
    .dm_addr_i      (dmAddr),
    .dm_data_i      (dmWdata),
    .dm_data_o      (dmRdata),
    .dm_ready_o     (dmReady),
    .stallreq_if_o  (stallReqIf),
    .stallreq_mem_o (stallReqMem),
    .bus            (bus)
  );

  // Reset values, and stall requests following inputs while reset is held
  task automatic test_reset();
    rst = 1'b0; stallVec = '0; flush = 1'b0; ifReq = 1'b1; ifAddr = '0;
    dmReq = 1'b1; dmWe = 1'b0; dmSel = '0; dmAddr = '0; dmWdata = '0;
    bus.ack = 1'b0; bus.rdata = '0;
    @(negedge clk); #1;
    checkCount++; if (bus.cyc !== 1'b0) $display("[TB] FAIL reset_cyc got %h want 0", bus.cyc); else passCount++;
    checkCount++; if (bus.stb !== 1'b0) $display("[TB] FAIL reset_stb got %h want 0", bus.stb); else passCount++;
    checkCount++; if (bus.we !== 1'b0) $display("[TB] FAIL reset_we got %h want 0", bus.we); else passCount++;
    checkCount++; if (bus.sel !== 4'h0) $display("[TB] FAIL reset_sel got %h want 0", bus.sel); else passCount++;
    checkCount++; if (bus.addr !== 32'h0) $display("[TB] FAIL reset_addr got %h want 0", bus.addr); else passCount++;
    checkCount++; if (bus.wdata !== 32'h0) $display("[TB] FAIL reset_wdata got %h want 0", bus.wdata); else passCount++;
    checkCount++; if (bus.err !== 1'b0) $display("[TB] FAIL reset_err got %h want 0", bus.err); else passCount++;
    checkCount++; if (dmRdata !== 32'h0) $display("[TB] FAIL reset_dm_data got %h want 0", dmRdata); else passCount++;
    checkCount++; if (ifData !== 32'h0) $display("[TB] FAIL reset_if_data got %h want 0", ifData); else passCount++;
    checkCount++; if (ifReady !== 1'b0) $display("[TB] FAIL reset_if_ready got %h want 0", ifReady); else passCount++;
    checkCount++; if (dmReady !== 1'b0) $display("[TB] FAIL reset_dm_ready got %h want 0", dmReady); else passCount++;
    checkCount++; if (stallReqIf !== 1'b1) $display("[TB] FAIL reset_stallreq_if got %h want 1", stallReqIf); else passCount++;
    checkCount++; if (stallReqMem !== 1'b1) $display("[TB] FAIL reset_stallreq_mem got %h want 1", stallReqMem); else passCount++;
    ifReq = 1'b0; dmReq = 1'b0; #1;
    checkCount++; if (stallReqIf !== 1'b0) $display("[TB] FAIL reset_stallreq_if_low got %h want 0", stallReqIf); else passCount++;
    checkCount++; if (stallReqMem !== 1'b0) $display("[TB] FAIL reset_stallreq_mem_low got %h want 0", stallReqMem); else passCount++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Fetch from a zero-wait slave: ready two cycles after the request edge
  task automatic test_fetch_zero_wait();
    ifReq = 1'b1; ifAddr = 32'h100; #1;
    checkCount++; if (stallReqIf !== 1'b1) $display("[TB] FAIL fetch_stallreq_if got %h want 1", stallReqIf); else passCount++;
    @(negedge clk);
    checkCount++; if (bus.cyc !== 1'b1 || bus.stb !== 1'b1) $display("[TB] FAIL fetch_cyc_stb got %h%h want 11", bus.cyc, bus.stb); else passCount++;
    checkCount++; if (bus.addr !== 32'h100) $display("[TB] FAIL fetch_addr got %h want 00000100", bus.addr); else passCount++;
    checkCount++; if (bus.we !== 1'b0 || bus.sel !== 4'hF) $display("[TB] FAIL fetch_we_sel got %h/%h want 0/f", bus.we, bus.sel); else passCount++;
    checkCount++; if (ifReady !== 1'b0) $display("[TB] FAIL fetch_ready_early got %h want 0", ifReady); else passCount++;
    bus.ack = 1'b1; bus.rdata = 32'h2401_0001;
    @(negedge clk);
    bus.ack = 1'b0;
    checkCount++; if (ifReady !== 1'b1) $display("[TB] FAIL fetch_ready got %h want 1", ifReady); else passCount++;
    checkCount++; if (ifData !== 32'h2401_0001) $display("[TB] FAIL fetch_data got %h want 24010001", ifData); else passCount++;
    checkCount++; if (bus.cyc !== 1'b0) $display("[TB] FAIL fetch_cyc_drop got %h want 0", bus.cyc); else passCount++;
    checkCount++; if (stallReqIf !== 1'b0) $display("[TB] FAIL fetch_stallreq_drop got %h want 0", stallReqIf); else passCount++;
    ifReq = 1'b0;
    @(negedge clk);
    checkCount++; if (ifReady !== 1'b0) $display("[TB] FAIL fetch_consumed got %h want 0", ifReady); else passCount++;
    checkCount++; if (bus.cyc !== 1'b0) $display("[TB] FAIL fetch_no_refetch got %h want 0", bus.cyc); else passCount++;
  endtask

  // MEM wins a tie; the fetch is granted after DM_DONE and one idle cycle
  task automatic test_back_to_back();
    dmReq = 1'b1; dmWe = 1'b1; dmSel = 4'hF; dmAddr = 32'h200; dmWdata = 32'hDEAD_BEEF;
    ifReq = 1'b1; ifAddr = 32'h300; #1;
    checkCount++; if (stallReqMem !== 1'b1) $display("[TB] FAIL b2b_stallreq_mem got %h want 1", stallReqMem); else passCount++;
    @(negedge clk);
    checkCount++; if (bus.cyc !== 1'b1 || bus.we !== 1'b1) $display("[TB] FAIL b2b_write_cyc_we got %h%h want 11", bus.cyc, bus.we); else passCount++;
    checkCount++; if (bus.addr !== 32'h200) $display("[TB] FAIL b2b_write_addr got %h want 00000200", bus.addr); else passCount++;
    checkCount++; if (bus.wdata !== 32'hDEAD_BEEF) $display("[TB] FAIL b2b_write_data got %h want deadbeef", bus.wdata); else passCount++;
    checkCount++; if (stallReqIf !== 1'b1) $display("[TB] FAIL b2b_if_waits got %h want 1", stallReqIf); else passCount++;
    bus.ack = 1'b1; bus.rdata = 32'h0;
    @(negedge clk);
    bus.ack = 1'b0;
    checkCount++; if (dmReady !== 1'b1) $display("[TB] FAIL b2b_dm_ready got %h want 1", dmReady); else passCount++;
    checkCount++; if (bus.cyc !== 1'b0) $display("[TB] FAIL b2b_cyc_drop got %h want 0", bus.cyc); else passCount++;
    checkCount++; if (stallReqMem !== 1'b0) $display("[TB] FAIL b2b_stallreq_mem_done got %h want 0", stallReqMem); else passCount++;
    dmReq = 1'b0; dmWe = 1'b0;
    @(negedge clk);
    checkCount++; if (dmReady !== 1'b0) $display("[TB] FAIL b2b_dm_ready_pulse got %h want 0", dmReady); else passCount++;
    checkCount++; if (bus.cyc !== 1'b0) $display("[TB] FAIL b2b_idle_gap got %h want 0", bus.cyc); else passCount++;
    @(negedge clk);
    checkCount++; if (bus.cyc !== 1'b1 || bus.addr !== 32'h300) $display("[TB] FAIL b2b_fetch_start got %h/%h want 1/00000300", bus.cyc, bus.addr); else passCount++;
    checkCount++; if (bus.we !== 1'b0) $display("[TB] FAIL b2b_fetch_we got %h want 0", bus.we); else passCount++;
    bus.ack = 1'b1; bus.rdata = 32'h1111_2222;
    @(negedge clk);
    bus.ack = 1'b0; ifReq = 1'b0;
    checkCount++; if (ifReady !== 1'b1 || ifData !== 32'h1111_2222) $display("[TB] FAIL b2b_fetch_data got %h/%h want 1/11112222", ifReady, ifData); else passCount++;
    @(negedge clk);
  endtask

  // Flush one cycle into a fetch: drain until ack, discard, refetch new PC
  task automatic test_flush_fetch();
    ifReq = 1'b1; ifAddr = 32'h500;
    @(negedge clk);
    checkCount++; if (bus.cyc !== 1'b1 || bus.addr !== 32'h500) $display("[TB] FAIL flush_fetch_start got %h/%h want 1/00000500", bus.cyc, bus.addr); else passCount++;
    flush = 1'b1; ifAddr = 32'h40; #1;
    checkCount++; if (stallReqIf !== 1'b0) $display("[TB] FAIL flush_stallreq_if got %h want 0", stallReqIf); else passCount++;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkCount++; if (bus.cyc !== 1'b1 || bus.stb !== 1'b1) $display("[TB] FAIL flush_drain_hold got %h%h want 11", bus.cyc, bus.stb); else passCount++;
      checkCount++; if (ifReady !== 1'b0) $display("[TB] FAIL flush_drain_ready got %h want 0", ifReady); else passCount++;
      @(negedge clk);
    end
    checkCount++; if (bus.cyc !== 1'b1) $display("[TB] FAIL flush_drain_pre_ack got %h want 1", bus.cyc); else passCount++;
    bus.ack = 1'b1; bus.rdata = 32'hBADB_AD00;
    @(negedge clk);
    bus.ack = 1'b0;
    checkCount++; if (bus.cyc !== 1'b0) $display("[TB] FAIL flush_drain_end got %h want 0", bus.cyc); else passCount++;
    checkCount++; if (ifReady !== 1'b0) $display("[TB] FAIL flush_discard got %h want 0", ifReady); else passCount++;
    @(negedge clk);
    checkCount++; if (bus.cyc !== 1'b1 || bus.addr !== 32'h40) $display("[TB] FAIL flush_refetch got %h/%h want 1/00000040", bus.cyc, bus.addr); else passCount++;
    bus.ack = 1'b1; bus.rdata = 32'h0000_0013;
    @(negedge clk);
    bus.ack = 1'b0; ifReq = 1'b0;
    checkCount++; if (ifReady !== 1'b1 || ifData !== 32'h13) $display("[TB] FAIL flush_refetch_data got %h/%h want 1/00000013", ifReady, ifData); else passCount++;
    @(negedge clk);
  endtask

  // Word held under stall while a data read completes
  task automatic test_held_word();
    ifReq = 1'b1; ifAddr = 32'h600; stallVec = 6'b001111;
    @(negedge clk);
    bus.ack = 1'b1; bus.rdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus.ack = 1'b0;
    checkCount++; if (stallReqIf !== 1'b0) $display("[TB] FAIL held_stallreq_if got %h want 0", stallReqIf); else passCount++;
    dmReq = 1'b1; dmWe = 1'b0; dmSel = 4'hF; dmAddr = 32'h700;
    for (int i = 0; i < 4; i++) begin
      checkCount++; if (ifReady !== 1'b1 || ifData !== 32'hCAFE_F00D) $display("[TB] FAIL held_word_%0d got %h/%h want 1/cafef00d", i, ifReady, ifData); else passCount++;
      if (i == 1) begin
        checkCount++; if (bus.cyc !== 1'b1 || bus.addr !== 32'h700 || bus.we !== 1'b0) $display("[TB] FAIL held_dm_read got %h/%h/%h want 1/00000700/0", bus.cyc, bus.addr, bus.we); else passCount++;
        bus.ack = 1'b1; bus.rdata = 32'h1234_5678;
      end
      if (i == 2) begin
        checkCount++; if (dmReady !== 1'b1 || dmRdata !== 32'h1234_5678) $display("[TB] FAIL held_dm_done got %h/%h want 1/12345678", dmReady, dmRdata); else passCount++;
        dmReq = 1'b0;
      end
      if (i == 3) begin
        stallVec = 6'b000000; ifReq = 1'b0;
      end
      @(negedge clk);
      bus.ack = 1'b0;
    end
    checkCount++; if (ifReady !== 1'b0) $display("[TB] FAIL held_consumed got %h want 0", ifReady); else passCount++;
  endtask

  // Unacked data read times out after 4 strobe cycles
  task automatic test_timeout();
    dmReq = 1'b1; dmWe = 1'b0; dmSel = 4'hF; dmAddr = 32'h800;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checkCount++; if (bus.cyc !== 1'b1 || bus.err !== 1'b0) $display("[TB] FAIL timeout_wait_%0d got %h/%h want 1/0", i, bus.cyc, bus.err); else passCount++;
      @(negedge clk);
    end
    checkCount++; if (bus.cyc !== 1'b0 || bus.stb !== 1'b0) $display("[TB] FAIL timeout_cyc_drop got %h%h want 00", bus.cyc, bus.stb); else passCount++;
    checkCount++; if (bus.err !== 1'b1) $display("[TB] FAIL timeout_err got %h want 1", bus.err); else passCount++;
    checkCount++; if (dmReady !== 1'b1 || dmRdata !== 32'h0) $display("[TB] FAIL timeout_dm_done got %h/%h want 1/00000000", dmReady, dmRdata); else passCount++;
    dmReq = 1'b0;
    @(negedge clk);
    checkCount++; if (bus.err !== 1'b0 || dmReady !== 1'b0) $display("[TB] FAIL timeout_pulse got %h/%h want 0/0", bus.err, dmReady); else passCount++;
  endtask

  // Asynchronous reset abandons an in-flight fetch
  task automatic test_reset_mid();
    ifReq = 1'b1; ifAddr = 32'h900;
    @(negedge clk);
    checkCount++; if (bus.cyc !== 1'b1) $display("[TB] FAIL rstmid_cyc_before got %h want 1", bus.cyc); else passCount++;
    #2 rst = 1'b0; #1;
    checkCount++; if (bus.cyc !== 1'b0 || bus.stb !== 1'b0) $display("[TB] FAIL rstmid_cyc_async got %h%h want 00", bus.cyc, bus.stb); else passCount++;
    checkCount++; if (bus.addr !== 32'h0 || ifData !== 32'h0) $display("[TB] FAIL rstmid_clear got %h/%h want 0/0", bus.addr, ifData); else passCount++;
    checkCount++; if (ifReady !== 1'b0 || dmReady !== 1'b0) $display("[TB] FAIL rstmid_ready got %h/%h want 0/0", ifReady, dmReady); else passCount++;
    @(negedge clk);
    ifReq = 1'b0; rst = 1'b1;
    @(negedge clk);
    checkCount++; if (bus.cyc !== 1'b0) $display("[TB] FAIL rstmid_idle got %h want 0", bus.cyc); else passCount++;
    ifReq = 1'b1; ifAddr = 32'hA00;
    @(negedge clk);
    checkCount++; if (bus.cyc !== 1'b1 || bus.addr !== 32'hA00) $display("[TB] FAIL rstmid_new_fetch got %h/%h want 1/00000a00", bus.cyc, bus.addr); else passCount++;
    bus.ack = 1'b1; bus.rdata = 32'h5555_AAAA;
    @(negedge clk);
    bus.ack = 1'b0; ifReq = 1'b0;
    checkCount++; if (ifReady !== 1'b1 || ifData !== 32'h5555_AAAA) $display("[TB] FAIL rstmid_fetch_data got %h/%h want 1/5555aaaa", ifReady, ifData); else passCount++;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_time_limit reached without completion");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    test_reset();
    test_fetch_zero_wait();
    test_back_to_back();
    test_flush_fetch();
    test_held_word();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequences the single shared memory bus port between the instruction-fetch path (IF) and the data-access path (MEM). It runs one bus transaction at a time, with fixed priority to MEM. It holds returned instruction words while the pipeline is stalled and discards fetches that are in flight when a flush occurs. It generates the IF and MEM stall requests consumed by `ctrl`, and watches `ctrl`'s `stall` and `flush` outputs.

## Interface
- `TIMEOUT`, default 255: maximum cycles to wait for `bus_ack_i`; 0 disables the watchdog.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `stall_i`  in  6  `ctrl` stall vector; bit 1 = IF/ID stage held.
- `flush_i`  in  1  `ctrl` pipeline flush.
- `if_req_i`  in  1  IF wants an instruction word.
- `if_addr_i`  in  32  fetch address (PC).
- `if_data_o`  out  32  fetched instruction.
- `if_ready_o`  out  1  `if_data_o` valid.
- `dm_req_i`  in  1  MEM wants a data access.
- `dm_we_i`  in  1  1 = write.
- `dm_sel_i`  in  4  byte enables.
- `dm_addr_i`  in  32  data address.
- `dm_data_i`  in  32  write data.
- `dm_data_o`  out  32  read data.
- `dm_ready_o`  out  1  data access complete (1-cycle pulse).
- `stallreq_if_o`  out  1  IF stall request to `ctrl`.
- `stallreq_mem_o`  out  1  MEM stall request to `ctrl`.
- `bus_cyc_o`, `bus_stb_o`  out  1 each  bus cycle/strobe.
- `bus_we_o`  out  1  bus write enable.
- `bus_sel_o`  out  4  bus byte enables.
- `bus_addr_o`  out  32  bus address.
- `bus_data_o`  out  32  bus write data.
- `bus_data_i`  in  32  bus read data.
- `bus_ack_i`  in  1  bus acknowledge.
- `bus_err_o`  out  1  1-cycle pulse on watchdog timeout.

## Operation
- States: IDLE, DM_ACC, IF_ACC, IF_DRAIN, DM_DONE. Separate flag `if_valid` with buffer `if_buf`.
- IDLE, in priority order:
  - `dm_req_i` → DM_ACC. Latch we/sel/addr/data onto the bus outputs and raise cyc/stb.
  - Otherwise `if_req_i & !if_valid & !flush_i` → IF_ACC. Put `if_addr_i` on the bus with `we=0` and `sel=4'hF`.
- DM_ACC: on `bus_ack_i`, capture `bus_data_i` into `dm_data_o`, drop cyc/stb, go to DM_DONE. `flush_i` is ignored here; MEM-stage exceptions suppress `dm_req_i` upstream.
- DM_DONE: `dm_ready_o=1` for exactly one cycle, then → IDLE.
- IF_ACC:
  - `bus_ack_i` with no `flush_i`: `if_buf←bus_data_i`, set `if_valid`, → IDLE.
  - `bus_ack_i` together with `flush_i`: discard the data, → IDLE.
  - `flush_i` without ack: → IF_DRAIN.
- IF_DRAIN: keep cyc/stb until `bus_ack_i`, discard the data, → IDLE.
- `if_valid` is cleared on any edge where `flush_i=1`, or where `if_valid=1` and `stall_i[1]=0` (word consumed). While `stall_i[1]=1` the word is held. A MEM access may proceed while it is held.
- `if_ready_o=if_valid`, `if_data_o=if_buf`.
- `stallreq_mem_o = dm_req_i & (state≠DM_DONE)`, combinational.
- `stallreq_if_o = if_req_i & !if_valid & !flush_i`, combinational.
- Watchdog:
  - Counter reset on entry to any ACC or DRAIN state, incremented each cycle without ack.
  - When it reaches `TIMEOUT`, drop cyc/stb and pulse `bus_err_o`. An access state then completes as if acked with data `32'h0`; DRAIN goes to IDLE.

## Timing
- Reset (async, `rst=0`): state IDLE. All outputs 0: cyc, stb, we, sel, addr, bus_data, `dm_data_o`, `if_data_o`, both ready signals, `bus_err_o`. `if_valid=0`, watchdog counter 0. Stall requests follow their equations, i.e. reflect the inputs. Reset mid-transaction abandons the access immediately.
- All bus and ready outputs are registered.
- Request sampled at edge t → cyc/stb high after t → ack sampled at edge t+k → ready high during cycle t+k+1.
- Zero-wait slave (ack in first strobe cycle): 3-cycle access, ready in cycle t+2.
- Back-to-back: from DM_DONE or ack into IDLE, the next grant is evaluated one cycle later. There is one idle bus cycle between transactions.
- `dm_req_i` and `if_req_i` in the same IDLE cycle: MEM wins. IF waits, with `stallreq_if_o` asserted.

## Structure
- State encodings and `TIMEOUT` default go in the shared defines file alongside `ZeroWord`/`Stop`.
- The watchdog is a natural sub-module: `bus_watchdog` (start, ack, expire; parameter `TIMEOUT`). Everything else stays in one module.

## Test plan
- Fetch, zero-wait slave: `if_req_i=1`, `addr=0x100`, ack in first stb cycle with `0x24010001` → `bus_addr_o=0x100`; `if_ready_o=1`, `if_data_o=0x24010001` in cycle 2; `stallreq_if_o` drops the same cycle.
- Simultaneous requests: dm write `addr=0x200`, `data=0xDEADBEEF`, `sel=0xF` plus an IF request → write goes first with `bus_we_o=1`; `dm_ready_o` pulses once; fetch starts one cycle after DM_DONE.
- Flush during fetch: flush one cycle after stb, ack 3 cycles later → cyc held until ack; `if_ready_o` stays 0; no `if_valid`; next fetch uses the new `if_addr_i` (e.g. `0x40`).
- Held word: fetch completes while `stall_i=6'b001111` for 4 cycles with a dm read issued meanwhile → `if_data_o` stable all 4 cycles; dm read completes; `if_valid` clears the edge after `stall_i[1]=0`.
- Timeout: `TIMEOUT=4`, slave never acks a dm read → cyc/stb drop after 4 cycles; `bus_err_o` pulses one cycle; `dm_ready_o=1` with `dm_data_o=0`.
- Reset mid-access: `rst=0` during IF_ACC → cyc/stb/ready fall asynchronously; after release state is IDLE.
